shift_rows: RTL and testbench

AES-128 ShiftRows stage for the pipelined datapath, with a registered output. Sits between SubBytes and MixColumns. A mode input selects the forward (encrypt) or inverse (decrypt) row rotation. Output latency is one clock.

---
 rtl/shift_rows_if.sv | 27 ++
 rtl/shift_rows.sv | 45 ++++
 tb/tb_shift_rows.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/shift_rows_if.sv
// Handshake and data bundle for the AES ShiftRows stage.
// The producer drives a state and its mode; the stage returns the registered result.
interface shift_rows_if;
    localparam int unsigned STATE_W = 128;

    logic               in_valid;
    logic               inv;
    logic [STATE_W-1:0] state_in;
    logic [STATE_W-1:0] state_out;
    logic               out_valid;

    modport master (
        output in_valid,
        output inv,
        output state_in,
        input  state_out,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  inv,
        input  state_in,
        output state_out,
        output out_valid
    );
endinterface

// File: rtl/shift_rows.sv
// AES-128 ShiftRows / InvShiftRows with a one-cycle registered output.
// Byte k sits at row k%4, column k/4; b0 occupies the top byte of the state.
module shift_rows (
    input  logic         clk,
    input  logic         rst,
    shift_rows_if.slave  bus
);
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned N_ROWS  = 4;
    localparam int unsigned N_COLS  = 4;
    localparam int unsigned STATE_W = BYTE_W * N_ROWS * N_COLS;

    logic [STATE_W-1:0] shifted;
    logic [STATE_W-1:0] state_q;
    logic               valid_q;

    // Row r rotates left by r (forward) or right by r (inverse); row 0 never moves.
    always_comb begin
        shifted = '0;
        for (int unsigned c = 0; c < N_COLS; c++) begin
            for (int unsigned r = 0; r < N_ROWS; r++) begin
                shifted[STATE_W-1-BYTE_W*(N_ROWS*c+r) -: BYTE_W] =
                    bus.inv
                        ? bus.state_in[STATE_W-1-BYTE_W*(N_ROWS*((c+N_COLS-r)%N_COLS)+r) -: BYTE_W]
                        : bus.state_in[STATE_W-1-BYTE_W*(N_ROWS*((c+r)%N_COLS)+r) -: BYTE_W];
            end
        end
    end

    // Result holds between transfers; out_valid pulses for one cycle per transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                state_q <= shifted;
            end
        end
    end

    assign bus.state_out = state_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_shift_rows.sv
// Directed vector table plus reset, hold and random streaming sequences for shift_rows.
// Expected values come from hand-computed vectors and an explicit output-byte-order model.
module tb_shift_rows;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    shift_rows_if bus ();

    shift_rows dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         inv;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[8];

    // Output byte i takes input byte idx[i], straight from the published byte orders.
    int fwd_idx[16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    int inv_idx[16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    function automatic logic [127:0] model(input logic [127:0] x, input logic m);
        logic [127:0] y;
        int src;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            src = m ? inv_idx[i] : fwd_idx[i];
            y[127-8*i -: 8] = x[127-8*src -: 8];
        end
        return y;
    endfunction

    task automatic check_state(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: state_out=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_valid(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: out_valid=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic m, input logic [127:0] x);
        bus.in_valid = v;
        bus.inv      = m;
        bus.state_in = x;
    endtask

    logic [127:0] held;
    logic [127:0] x;
    logic [127:0] exp_state;
    logic         exp_valid;
    logic         v;
    logic         m;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{"fips_fwd",   1'b0, 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2, 128'h632FAFA2EB93C7209F92ABCBA0C0302B};
        vecs[1] = '{"stream_fwd0", 1'b0, 128'h6AA0303D594E9CF4CB48989BBD129E8B, 128'h6A4E988B59489E3DCB1230F4BDA09C9B};
        vecs[2] = '{"stream_fwd1", 1'b0, 128'hC874D15530B020F8F2C8DD66943750B7, 128'hC8B0DDB730C85055F237D1F894742066};
        vecs[3] = '{"fips_inv",   1'b1, 128'h632FAFA2EB93C7209F92ABCBA0C0302B, 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2};
        vecs[4] = '{"idx_fwd",    1'b0, 128'h000102030405060708090A0B0C0D0E0F, 128'h00050A0F04090E03080D02070C01060B};
        vecs[5] = '{"idx_inv",    1'b1, 128'h000102030405060708090A0B0C0D0E0F, 128'h000D0A0704010E0B0805020F0C090603};
        vecs[6] = '{"stream_inv1", 1'b1, 128'hC8B0DDB730C85055F237D1F894742066, 128'hC874D15530B020F8F2C8DD66943750B7};
        vecs[7] = '{"stream_inv0", 1'b1, 128'h6A4E988B59489E3DCB1230F4BDA09C9B, 128'h6AA0303D594E9CF4CB48989BBD129E8B};

        // Power-on reset
        rst = 1'b1;
        drive(1'b0, 1'b0, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        check_state("reset_state", bus.state_out, 128'h0);
        check_valid("reset_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table, back-to-back with mode alternating mid-stream
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].inv, vecs[i].din);
            @(posedge clk);
            #1;
            check_state(vecs[i].name, bus.state_out, vecs[i].exp);
            check_valid({vecs[i].name, "_valid"}, bus.out_valid, 1'b1);
        end

        // Hold: three idle cycles with toggling inputs
        held = vecs[7].exp;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, i[0], {4{$urandom}});
            @(posedge clk);
            #1;
            check_state("hold_state", bus.state_out, held);
            check_valid("hold_valid", bus.out_valid, 1'b0);
        end

        // Asynchronous reset mid-stream, between clock edges
        @(negedge clk);
        drive(1'b1, 1'b0, vecs[0].din);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst_state", bus.state_out, 128'h0);
        check_valid("async_rst_valid", bus.out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_state("rst_held_state", bus.state_out, 128'h0);
        check_valid("rst_held_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, vecs[0].din);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_state("post_rst_idle_state", bus.state_out, 128'h0);
            check_valid("post_rst_idle_valid", bus.out_valid, 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, vecs[0].din);
        @(posedge clk);
        #1;
        check_state("first_after_rst", bus.state_out, vecs[0].exp);
        check_valid("first_after_rst_valid", bus.out_valid, 1'b1);

        // Random stream with gaps and mixed modes
        exp_state = vecs[0].exp;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            v = ($urandom_range(0, 9) < 7);
            m = 1'($urandom_range(0, 1));
            x = {$urandom, $urandom, $urandom, $urandom};
            drive(v, m, x);
            if (v) exp_state = model(x, m);
            exp_valid = v;
            @(posedge clk);
            #1;
            check_state("rand_state", bus.state_out, exp_state);
            check_valid("rand_valid", bus.out_valid, exp_valid);
        end

        // Round trip: inverse of forward restores the input
        for (int i = 0; i < 50; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            drive(1'b1, 1'b0, x);
            @(posedge clk);
            #1;
            check_state("rt_fwd", bus.state_out, model(x, 1'b0));
            held = bus.state_out;
            @(negedge clk);
            drive(1'b1, 1'b1, held);
            @(posedge clk);
            #1;
            check_state("rt_back", bus.state_out, x);
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 128'h0);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
